// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit port bundle: program load, control, redirect and the instruction
// valid/ready handshake toward the processor.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              start;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              instr_ready;
  logic              instr_valid;
  logic [31:0]       instruction;
  logic [31:0]       instr_pc;
  logic              busy;
  logic              halted;

  modport master (
    input  prog_we, prog_addr, prog_data, start, redirect_valid, redirect_pc, instr_ready,
    output instr_valid, instruction, instr_pc, busy, halted
  );

  modport slave (
    output prog_we, prog_addr, prog_data, start, redirect_valid, redirect_pc, instr_ready,
    input  instr_valid, instruction, instr_pc, busy, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, programmable instruction RAM and a one-word
// valid/ready output stage with branch redirect and halt-on-sentinel.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_HALTED
  } state_e;

  logic [31:0]       mem [DEPTH];
  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instruction_q, instruction_d;
  logic [31:0]       instr_pc_q, instr_pc_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic [31:0]       redirect_pc_aligned;
  logic [ADDR_W-1:0] rd_addr;

  assign redirect_pc_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

  // The RAM is read at every edge with the upcoming PC, so the word for a
  // FETCH cycle is already registered when that cycle begins.
  assign rd_addr = pc_d[ADDR_W+1:2];

  always_comb begin
    rdata_d = mem[rd_addr];
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    halted_d      = halted_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect_valid) pc_d = redirect_pc_aligned;
        if (bus.start)          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_pc_aligned;
        end else if (rdata_q == HALT_WORD) begin
          state_d       = S_HALTED;
          halted_d      = 1'b1;
          instr_valid_d = 1'b0;
        end else begin
          state_d       = S_VALID;
          instr_valid_d = 1'b1;
          instruction_d = rdata_q;
          instr_pc_d    = pc_q;
        end
      end
      S_VALID: begin
        // Redirect wins over a same-cycle accept; the accepted word is dropped.
        if (bus.redirect_valid) begin
          pc_d          = redirect_pc_aligned;
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end else if (bus.instr_ready) begin
          pc_d          = 32'(pc_q + 32'd4);
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_HALTED: begin
        if (bus.redirect_valid) begin
          pc_d     = redirect_pc_aligned;
          halted_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FETCH) || (state_d == S_VALID);
  end

  // Program writes and the read register share one edge; a same-address read
  // sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      instruction_q <= 32'h0;
      instr_pc_q    <= 32'h0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.instr_valid = instr_valid_q;
  assign bus.instruction = instruction_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, word} pushed when a fetch
// is requested, popped when the DUT presents a valid instruction.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   lat;
  exp_t sb [$];
  logic [31:0] ram_m [256];

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [7:0] addr, input logic [31:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    ram_m[addr]   = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    logic [7:0] idx;
    exp_t e;
    idx   = pc[9:2];
    e.pc  = pc;
    e.ins = ram_m[idx];
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    check_val({tag, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({tag, "_pc"},  bus.instr_pc,    e.pc);
      check_val({tag, "_ins"}, bus.instruction, e.ins);
    end
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = 0;
    while (cycles <= max) begin
      tick();
      cycles++;
      if (bus.instr_valid) break;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"},  32'(bus.instr_valid), 32'd0);
    check_val({tag, "_ins"},    bus.instruction,      32'd0);
    check_val({tag, "_pc"},     bus.instr_pc,         32'd0);
    check_val({tag, "_busy"},   32'(bus.busy),        32'd0);
    check_val({tag, "_halted"}, 32'(bus.halted),      32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst                = 1'b1;
    bus.prog_we        = 1'b0;
    bus.prog_addr      = '0;
    bus.prog_data      = '0;
    bus.start          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    tick();
    tick();

    prog(8'd0,   32'h0022_1820);
    prog(8'd1,   32'h0043_2020);
    prog(8'd2,   32'h0064_3020);
    prog(8'd3,   32'hFFFF_FFFF);
    prog(8'd255, 32'h1234_5678);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Straight-line run with ready held high, ending on the halt sentinel
    bus.instr_ready = 1'b1;
    bus.start       = 1'b1;
    push_exp(32'h0);
    tick();
    bus.start = 1'b0;
    check_val("fetch_busy",  32'(bus.busy),        32'd1);
    check_val("fetch_valid", 32'(bus.instr_valid), 32'd0);
    wait_valid(4, lat);
    check_val("lat_first", 32'(lat), 32'd1);
    pop_cmp("run0");
    push_exp(32'h4);
    wait_valid(4, lat);
    check_val("lat_run4", 32'(lat), 32'd2);
    pop_cmp("run4");
    push_exp(32'h8);
    wait_valid(4, lat);
    check_val("lat_run8", 32'(lat), 32'd2);
    pop_cmp("run8");
    tick();
    tick();
    check_val("halt_halted", 32'(bus.halted),      32'd1);
    check_val("halt_busy",   32'(bus.busy),        32'd0);
    check_val("halt_valid",  32'(bus.instr_valid), 32'd0);

    // Start is ignored while halted; only redirect resumes
    bus.instr_ready = 1'b0;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_val("halt_start_halted", 32'(bus.halted), 32'd1);
    check_val("halt_start_busy",   32'(bus.busy),   32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h4;
    push_exp(32'h4);
    tick();
    bus.redirect_valid = 1'b0;
    check_val("resume_halted", 32'(bus.halted), 32'd0);
    check_val("resume_busy",   32'(bus.busy),   32'd1);
    wait_valid(4, lat);
    check_val("lat_resume", 32'(lat), 32'd1);
    pop_cmp("resume4");

    // Backpressure: outputs frozen while ready is low
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_valid", 32'(bus.instr_valid), 32'd1);
      check_val("bp_pc",    bus.instr_pc,         32'h4);
      check_val("bp_ins",   bus.instruction,      ram_m[1]);
    end
    bus.instr_ready = 1'b1;
    push_exp(32'h8);
    tick();
    bus.instr_ready = 1'b0;
    check_val("bp_accept_valid", 32'(bus.instr_valid), 32'd0);
    wait_valid(4, lat);
    check_val("lat_bp", 32'(lat), 32'd1);
    pop_cmp("bp8");

    // Redirect beats a same-cycle accept; target aliases above the RAM depth
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_03FC;
    push_exp(32'h3FC);
    tick();
    bus.redirect_valid = 1'b0;
    wait_valid(4, lat);
    check_val("lat_redir3fc", 32'(lat), 32'd1);
    pop_cmp("redir3fc");
    push_exp(32'h400);
    wait_valid(4, lat);
    check_val("lat_alias", 32'(lat), 32'd2);
    pop_cmp("alias400");

    // Misaligned redirect target is word-aligned; pending accept dropped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_000A;
    push_exp(32'h8);
    tick();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    wait_valid(4, lat);
    check_val("lat_redir_a", 32'(lat), 32'd1);
    pop_cmp("redir_a");

    // Reset mid-transfer, then refetch with a write landing during FETCH
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midrst");
    bus.start = 1'b1;
    push_exp(32'h0);
    tick();
    bus.start = 1'b0;
    prog(8'd0, 32'hCAFE_0001);
    check_val("rw_valid", 32'(bus.instr_valid), 32'd1);
    pop_cmp("rw_old");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    push_exp(32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    wait_valid(4, lat);
    check_val("lat_rw_new", 32'(lat), 32'd1);
    pop_cmp("rw_new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
